// File: rtl/dmem_write_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_write_arbiter_if : requester handshakes plus data-memory write port
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_write_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int MW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [MW-1:0] req0_wmask;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [MW-1:0] req1_wmask;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;

    logic          busy;
    logic          grant_id;
    logic [31:0]   wr_count;

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_wmask,
        output req1_valid, req1_addr, req1_wdata, req1_wmask,
        input  req0_ready, req1_ready,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_wmask,
        input  busy, grant_id, wr_count
    );

    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_wmask,
        input  req1_valid, req1_addr, req1_wdata, req1_wmask,
        output req0_ready, req1_ready,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_wmask,
        output busy, grant_id, wr_count
    );
endinterface

`default_nettype wire

// File: rtl/dmem_write_arbiter.sv
//------------------------------------------------------------------------------
// dmem_write_arbiter : two-requester round-robin scheduler for the dmem write port
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_write_arbiter #(
    parameter int AW          = 64,
    parameter int DW          = 64,
    parameter int MW          = 8,
    parameter int BUSY_CYCLES = 1
) (
    input  wire logic           clock,
    input  wire logic           reset,
    dmem_write_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [3:0] HOLD_LOAD = 4'(BUSY_CYCLES - 1);
    localparam bit         PIPELINED = (BUSY_CYCLES == 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [3:0]    hold_cnt;
    logic          rr_ptr;
    logic          window;
    logic          winner;
    logic          handshake;
    logic [MW-1:0] win_wmask;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic          grant_q;
    logic [31:0]   count_q;

    // Arbitration: rr_ptr only matters when both requesters compete
    always_comb begin
        window    = (state == S_IDLE) || ((state == S_WRITE) && PIPELINED);
        winner    = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
        bus.req0_ready = window && !reset && bus.req0_valid && !winner;
        bus.req1_ready = window && !reset && bus.req1_valid &&  winner;
        handshake = bus.req0_ready || bus.req1_ready;
        win_wmask = winner ? bus.req1_wmask : bus.req0_wmask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state == S_WRITE) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = handshake ? S_WRITE : S_IDLE;
            S_WRITE: begin
                if (PIPELINED) begin
                    state_next = handshake ? S_WRITE : S_IDLE;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD:  state_next = (hold_cnt == 4'd1) ? S_IDLE : S_HOLD;
            default: state_next = S_IDLE;
        endcase
    end

    // Count is bumped on the accepting edge so it already includes the pulse being issued
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            grant_q <= 1'b0;
            count_q <= 32'd0;
        end else if (handshake) begin
            rr_ptr  <= ~winner;
            addr_q  <= winner ? bus.req1_addr  : bus.req0_addr;
            wdata_q <= winner ? bus.req1_wdata : bus.req0_wdata;
            wmask_q <= win_wmask;
            grant_q <= winner;
            if (win_wmask != '0) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        bus.mem_en    = (state == S_WRITE) && (wmask_q != '0);
        bus.mem_wr    = bus.mem_en;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wmask = wmask_q;
        bus.busy      = (state != S_IDLE);
        bus.grant_id  = grant_q;
        bus.wr_count  = count_q;
    end
endmodule

`default_nettype wire
